// File: rtl/genesis_bus_pkg.sv
// genesis_bus_pkg
// Shared definitions for the 68000-side bus responders.
//   zram_state_e  : responder FSM states
//   ZRAM_BASE_DEF : default 68000 window (addr[23:16]) that maps onto Z80 RAM
//   Z80_RAM_OFS   : base of Z80 RAM within the 17-bit RAM byte address space
//   zram_addr()   : builds a RAM byte address from a 68000 word address + lane
package genesis_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI_ISSUE,
    ST_HI_WAIT,
    ST_LO_ISSUE,
    ST_LO_WAIT,
    ST_ACK
  } zram_state_e;

  localparam logic [7:0]  ZRAM_BASE_DEF = 8'hA0;
  localparam logic [16:0] Z80_RAM_OFS   = 17'h10000;

  // Upper byte lane (uds) sits at the even address, lower lane (lds) at odd.
  function automatic logic [16:0] zram_addr(input logic [14:0] word_addr,
                                            input logic        lo_lane);
    return Z80_RAM_OFS | {1'b0, word_addr, lo_lane};
  endfunction

endpackage

// File: rtl/m68k_zram_responder.sv
// m68k_zram_responder
// Answers 68000 bus cycles that fall in the Z80 RAM window by splitting each
// word access into up to two byte accesses on an 8-bit synchronous RAM port.
//
// Ports
//   clk, reset          : clock (rising edge), async active-high reset
//   as_n, uds_n, lds_n  : 68000 address / upper / lower data strobes (active low)
//   rw                  : 1 = read, 0 = write
//   addr[23:0]          : 68000 byte address (addr[0] unused)
//   cpu_wdata, cpu_rdata: CPU write / read data
//   dtack_n             : data acknowledge (active low)
//   ena, wea, addra,
//   dina, douta         : byte-wide RAM port, read latency RD_LAT clocks
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for a fresh address strobe
// ST_HI_ISSUE | RAM strobe for upper byte (even address) is on the port
// ST_HI_WAIT  | waiting out read latency, then capture upper byte
// ST_LO_ISSUE | RAM strobe for lower byte (odd address) is on the port
// ST_LO_WAIT  | waiting out read latency, then capture lower byte
// ST_ACK      | dtack asserted until the CPU drops as_n
module m68k_zram_responder
  import genesis_bus_pkg::*;
#(
  parameter logic [7:0] BASE   = ZRAM_BASE_DEF,
  parameter int         RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw,
  input  logic [23:0] addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        dtack_n,
  output logic        ena,
  output logic        wea,
  output logic [16:0] addra,
  output logic [7:0]  dina,
  input  logic [7:0]  douta
);

  // Wait state always lasts one clock; reads add RD_LAT-1 more on top.
  localparam logic [1:0] RD_WAIT = 2'(RD_LAT - 1);

  zram_state_e state;
  logic [1:0]  wait_cnt;
  logic [14:0] word_q;
  logic        rw_q;
  logic [15:0] wdata_q;
  logic        lds_q;
  // Previous as_n sample: a new cycle needs as_n seen high first, so a strobe
  // held low across reset or the end of ACK never starts a second access.
  logic        as_hi_q;

  logic unused_addr0;
  assign unused_addr0 = addr[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dtack_n   <= 1'b1;
      ena       <= 1'b0;
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      cpu_rdata <= 16'hFFFF;
      wait_cnt  <= '0;
      word_q    <= '0;
      rw_q      <= 1'b1;
      wdata_q   <= '0;
      lds_q     <= 1'b0;
      as_hi_q   <= 1'b0;
    end else begin
      as_hi_q <= as_n;
      // RAM strobes are single-clock pulses; only issue transitions raise them.
      ena     <= 1'b0;
      wea     <= 1'b0;

      case (state)
        ST_IDLE: begin
          dtack_n <= 1'b1;
          if (!as_n && as_hi_q) begin
            word_q    <= addr[15:1];
            rw_q      <= rw;
            wdata_q   <= cpu_wdata;
            lds_q     <= ~lds_n;
            cpu_rdata <= 16'hFFFF;
            if (addr[23:16] != BASE) begin
              state <= ST_ACK;
            end else if (!uds_n) begin
              state <= ST_HI_ISSUE;
              ena   <= 1'b1;
              wea   <= ~rw;
              addra <= zram_addr(addr[15:1], 1'b0);
              dina  <= cpu_wdata[15:8];
            end else if (!lds_n) begin
              state <= ST_LO_ISSUE;
              ena   <= 1'b1;
              wea   <= ~rw;
              addra <= zram_addr(addr[15:1], 1'b1);
              dina  <= cpu_wdata[7:0];
            end else begin
              state <= ST_ACK;
            end
          end
        end

        ST_HI_ISSUE: begin
          if (as_n) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_HI_WAIT;
            wait_cnt <= rw_q ? RD_WAIT : 2'd0;
          end
        end

        ST_LO_ISSUE: begin
          if (as_n) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_LO_WAIT;
            wait_cnt <= rw_q ? RD_WAIT : 2'd0;
          end
        end

        ST_HI_WAIT: begin
          if (as_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            if (rw_q) cpu_rdata[15:8] <= douta;
            if (lds_q) begin
              state <= ST_LO_ISSUE;
              ena   <= 1'b1;
              wea   <= ~rw_q;
              addra <= zram_addr(word_q, 1'b1);
              dina  <= wdata_q[7:0];
            end else begin
              state <= ST_ACK;
            end
          end
        end

        ST_LO_WAIT: begin
          if (as_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            if (rw_q) cpu_rdata[7:0] <= douta;
            state <= ST_ACK;
          end
        end

        ST_ACK: begin
          if (as_n) begin
            dtack_n <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            dtack_n <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_zram_responder.sv
// tb_m68k_zram_responder
// Two responders share one CPU bus: dut1 with RD_LAT=1, dut2 with RD_LAT=2,
// each with its own byte RAM. Table vectors and random cycles are checked
// against a byte-array model; a few hand sequences cover abort and reset.
module tb_m68k_zram_responder;

  logic        clk;
  logic        reset;
  logic        as_n, uds_n, lds_n, rw;
  logic [23:0] addr;
  logic [15:0] cpu_wdata;

  logic [15:0] cpu_rdata1, cpu_rdata2;
  logic        dtack_n1, dtack_n2;
  logic        ena1, ena2, wea1, wea2;
  logic [16:0] addra1, addra2;
  logic [7:0]  dina1, dina2, douta1, douta2;

  logic        pl_we;
  logic [16:0] pl_a;
  logic [7:0]  pl_d;

  logic [7:0] mem1   [0:131071];
  logic [7:0] mem2   [0:131071];
  logic [7:0] refmem [0:131071];
  logic [7:0] rd1_s1, rd2_s1, rd2_s2;

  int total = 0;
  int bad   = 0;
  int ena_cnt1 = 0;
  int ena_cnt2 = 0;
  int ena_run_err = 0;
  logic ena_prev1 = 1'b0;
  logic ena_prev2 = 1'b0;

  m68k_zram_responder #(.BASE(8'hA0), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .rw(rw), .addr(addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1),
    .dtack_n(dtack_n1), .ena(ena1), .wea(wea1), .addra(addra1),
    .dina(dina1), .douta(douta1)
  );

  m68k_zram_responder #(.BASE(8'hA0), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .rw(rw), .addr(addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata2),
    .dtack_n(dtack_n2), .ena(ena2), .wea(wea2), .addra(addra2),
    .dina(dina2), .douta(douta2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAMs; preload port lets the bench seed contents.
  always @(posedge clk) begin
    if (pl_we) begin
      mem1[pl_a] <= pl_d;
      mem2[pl_a] <= pl_d;
    end
    if (ena1) begin
      if (wea1) mem1[addra1] <= dina1;
      rd1_s1 <= mem1[addra1];
    end
    if (ena2) begin
      if (wea2) mem2[addra2] <= dina2;
      rd2_s1 <= mem2[addra2];
    end
    rd2_s2 <= rd2_s1;
  end
  assign douta1 = rd1_s1;
  assign douta2 = rd2_s2;

  always @(posedge clk) begin
    if (ena1) ena_cnt1 <= ena_cnt1 + 1;
    if (ena2) ena_cnt2 <= ena_cnt2 + 1;
  end

  // RAM strobe must never stay high for two consecutive clocks.
  always @(negedge clk) begin
    if ((ena1 && ena_prev1) || (ena2 && ena_prev2)) ena_run_err <= ena_run_err + 1;
    ena_prev1 <= ena1;
    ena_prev2 <= ena2;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    refmem[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Runs one full bus cycle from a negedge; returns at a negedge with as_n high.
  task automatic bus_cycle(input string nm, input logic [23:0] a, input logic u,
                           input logic l, input logic r, input logic [15:0] wd,
                           input logic [15:0] exp_rd, input int exp_l1,
                           input int exp_l2, input int exp_en);
    int e1, e2, lat1, lat2;
    logic [15:0] rd1, rd2;
    logic hold_ok;
    logic [16:0] wa;
    e1 = ena_cnt1;
    e2 = ena_cnt2;
    lat1 = -1;
    lat2 = -1;
    addr = a; uds_n = ~u; lds_n = ~l; rw = r; cpu_wdata = wd; as_n = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (lat1 < 0 && !dtack_n1) lat1 = k;
      if (lat2 < 0 && !dtack_n2) lat2 = k;
      if (lat1 >= 0 && lat2 >= 0) break;
      @(posedge clk);
    end
    chk({nm, "/lat1"}, 64'(lat1), 64'(exp_l1));
    chk({nm, "/lat2"}, 64'(lat2), 64'(exp_l2));
    if (r) begin
      chk({nm, "/rdata1"}, 64'(cpu_rdata1), 64'(exp_rd));
      chk({nm, "/rdata2"}, 64'(cpu_rdata2), 64'(exp_rd));
    end
    rd1 = cpu_rdata1;
    rd2 = cpu_rdata2;
    hold_ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (dtack_n1 || dtack_n2 || cpu_rdata1 !== rd1 || cpu_rdata2 !== rd2) hold_ok = 1'b0;
    end
    chk({nm, "/ack_hold"}, 64'(hold_ok), 64'd1);
    as_n = 1'b1;
    @(negedge clk);
    chk({nm, "/release"}, 64'({dtack_n1, dtack_n2}), 64'b11);
    chk({nm, "/ena1"}, 64'(ena_cnt1 - e1), 64'(exp_en));
    chk({nm, "/ena2"}, 64'(ena_cnt2 - e2), 64'(exp_en));
    wa = {1'b1, a[15:1], 1'b0};
    if (!r && a[23:16] == 8'hA0) begin
      if (u) refmem[wa] = wd[15:8];
      if (l) refmem[wa | 17'd1] = wd[7:0];
      chk({nm, "/mem1"}, 64'({mem1[wa], mem1[wa | 17'd1]}),
          64'({refmem[wa], refmem[wa | 17'd1]}));
      chk({nm, "/mem2"}, 64'({mem2[wa], mem2[wa | 17'd1]}),
          64'({refmem[wa], refmem[wa | 17'd1]}));
    end
  endtask

  typedef struct {
    logic [23:0] a;
    logic        u, l, r;
    logic [15:0] wd;
    logic [15:0] rd;
    int          l1, l2, en;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int ena_base1, ena_base2;
    logic quiet_ok;

    tbl[0]  = '{24'hA00000, 1, 1, 1, 16'h0000, 16'h069A, 5, 7, 2};
    tbl[1]  = '{24'hA00004, 1, 0, 0, 16'h2E55, 16'hFFFF, 3, 3, 1};
    tbl[2]  = '{24'hA00004, 1, 1, 1, 16'h0000, 16'h2E77, 5, 7, 2};
    tbl[3]  = '{24'h000100, 1, 1, 1, 16'h0000, 16'hFFFF, 1, 1, 0};
    tbl[4]  = '{24'hA00000, 0, 1, 1, 16'h0000, 16'hFF9A, 3, 4, 1};
    tbl[5]  = '{24'hA00000, 0, 0, 1, 16'h0000, 16'hFFFF, 1, 1, 0};
    tbl[6]  = '{24'hA00010, 1, 1, 0, 16'h1234, 16'hFFFF, 5, 5, 2};
    tbl[7]  = '{24'hA00010, 1, 1, 1, 16'h0000, 16'h1234, 5, 7, 2};
    tbl[8]  = '{24'hA0FFFE, 1, 0, 1, 16'h0000, 16'hC3FF, 3, 4, 1};
    tbl[9]  = '{24'hA10000, 1, 1, 0, 16'hBEEF, 16'hFFFF, 1, 1, 0};
    tbl[10] = '{24'hA00001, 1, 1, 1, 16'h0000, 16'h069A, 5, 7, 2};

    reset = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    addr = '0; cpu_wdata = '0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    @(negedge clk);
    chk("reset_state1", 64'({dtack_n1, ena1, wea1, addra1, dina1, cpu_rdata1}),
        64'({1'b1, 1'b0, 1'b0, 17'h0, 8'h0, 16'hFFFF}));
    chk("reset_state2", 64'({dtack_n2, ena2, wea2, addra2, dina2, cpu_rdata2}),
        64'({1'b1, 1'b0, 1'b0, 17'h0, 8'h0, 16'hFFFF}));

    for (int i = 0; i < 128; i++) preload(17'h10000 + 17'(i), 8'($urandom));
    preload(17'h10000, 8'h06);
    preload(17'h10001, 8'h9A);
    preload(17'h10004, 8'h5A);
    preload(17'h10005, 8'h77);
    preload(17'h10020, 8'h11);
    preload(17'h10021, 8'h22);
    preload(17'h1FFFE, 8'hC3);
    preload(17'h1FFFF, 8'h3C);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      bus_cycle($sformatf("vec%0d", i), tbl[i].a, tbl[i].u, tbl[i].l, tbl[i].r,
                tbl[i].wd, tbl[i].rd, tbl[i].l1, tbl[i].l2, tbl[i].en);
      if (i == 1) begin
        chk("bytewr_hi", 64'(mem1[17'h10004]), 64'h2E);
        chk("bytewr_lo_kept", 64'(mem1[17'h10005]), 64'h77);
      end
    end

    // Word write aborted once the upper byte has been written.
    ena_base1 = ena_cnt1;
    ena_base2 = ena_cnt2;
    addr = 24'hA00020; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0; cpu_wdata = 16'hABCD;
    as_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 as_n = 1'b1;
    quiet_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (!dtack_n1 || !dtack_n2) quiet_ok = 1'b0;
    end
    refmem[17'h10020] = 8'hAB;
    chk("abort_no_dtack", 64'(quiet_ok), 64'd1);
    chk("abort_mem1", 64'({mem1[17'h10020], mem1[17'h10021]}), 64'h AB22);
    chk("abort_mem2", 64'({mem2[17'h10020], mem2[17'h10021]}), 64'h AB22);
    chk("abort_ena1", 64'(ena_cnt1 - ena_base1), 64'd1);
    chk("abort_ena2", 64'(ena_cnt2 - ena_base2), 64'd1);

    // Reset while the upper byte write strobe is on the RAM port.
    addr = 24'hA00030; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0; cpu_wdata = 16'h5566;
    as_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midwr_wea_before", 64'({wea1, wea2}), 64'b11);
    reset = 1'b1;
    #1;
    chk("midwr_wea_reset", 64'({wea1, wea2, ena1, ena2}), 64'b0000);
    as_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midwr_mem1", 64'({mem1[17'h10030], mem1[17'h10031]}),
        64'({refmem[17'h10030], refmem[17'h10031]}));
    chk("midwr_mem2", 64'({mem2[17'h10030], mem2[17'h10031]}),
        64'({refmem[17'h10030], refmem[17'h10031]}));

    // Reset during HI_WAIT of a word read, then strobe held low after release.
    addr = 24'hA00000; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; as_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_wait1", 64'({dtack_n1, ena1, wea1, addra1, dina1, cpu_rdata1}),
        64'({1'b1, 1'b0, 1'b0, 17'h0, 8'h0, 16'hFFFF}));
    chk("rst_wait2", 64'({dtack_n2, ena2, wea2, addra2, dina2, cpu_rdata2}),
        64'({1'b1, 1'b0, 1'b0, 17'h0, 8'h0, 16'hFFFF}));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ena_base1 = ena_cnt1;
    ena_base2 = ena_cnt2;
    quiet_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!dtack_n1 || !dtack_n2) quiet_ok = 1'b0;
    end
    chk("held_as_no_dtack", 64'(quiet_ok), 64'd1);
    chk("held_as_no_ena", 64'({32'(ena_cnt1 - ena_base1), 32'(ena_cnt2 - ena_base2)}), 64'd0);
    as_n = 1'b1;
    @(negedge clk);
    bus_cycle("post_reset_read", 24'hA00000, 1, 1, 1, 16'h0000,
              {refmem[17'h10000], refmem[17'h10001]}, 5, 7, 2);

    // Random cycles against the byte-array model.
    for (int i = 0; i < 60; i++) begin
      logic [23:0] a;
      logic u, l, r, inwin;
      logic [15:0] wd, er;
      logic [16:0] wa;
      int hi, lanes;
      inwin = ($urandom_range(0, 9) < 7);
      if (inwin) begin
        a = {8'hA0, 9'h0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1))};
      end else begin
        hi = $urandom_range(0, 254);
        if (hi >= 160) hi++;
        a = {8'(hi), 16'($urandom)};
      end
      u  = 1'($urandom_range(0, 1));
      l  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      wa = {1'b1, a[15:1], 1'b0};
      er = 16'hFFFF;
      if (inwin && r) begin
        if (u) er[15:8] = refmem[wa];
        if (l) er[7:0]  = refmem[wa | 17'd1];
      end
      lanes = inwin ? (int'(u) + int'(l)) : 0;
      bus_cycle($sformatf("rnd%0d", i), a, u, l, r, wd, er,
                1 + lanes * 2, 1 + lanes * (r ? 3 : 2), lanes);
    end

    chk("ena_single_clock", 64'(ena_run_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
